// File: rtl/waterfall_writer.sv
`timescale 1ns/1ps
// Waterfall row writer: compresses a spectrum frame of magnitude bins to 8-bit pixels and writes one circular-buffer row per capture.
// Latency: one cycle from bin handshake to RAM write; head_row advances in the COMMIT cycle after the last column write.
// Backpressure: s_bin_ready is high only while capturing or draining; IDLE/PAD/COMMIT stall the stream. Option macro: WATERFALL_MAX_POOL_EN.
module waterfall_writer #(
    parameter int NUM_ROWS       = 180,
    parameter int NUM_COLS       = 640,
    parameter int BIN_W          = 16,
    parameter int SHIFT          = 4,
    parameter int FRAMES_PER_ROW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] s_bin_data,
    input  logic             s_bin_valid,
    input  logic             s_bin_last,
    output logic             s_bin_ready,
    input  logic             vsync,
    output logic             wr_en,
    output logic [8:0]       wr_row,
    output logic [9:0]       wr_col,
    output logic [7:0]       wr_data,
    output logic [8:0]       head_row,
    output logic             overflow
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        PAD     = 3'd2,
        DRAIN   = 3'd3,
        COMMIT  = 3'd4
    } state_t;

    localparam logic [9:0] COL_LAST  = 10'(NUM_COLS - 1);
    localparam logic [8:0] ROW_LAST  = 9'(NUM_ROWS - 1);
    localparam logic [3:0] FCNT_LAST = 4'(FRAMES_PER_ROW - 1);

    state_t           state, state_d;
    logic             vsync_q;
    logic             tick;
    logic [3:0]       frame_cnt, frame_cnt_d;
    logic [9:0]       col, col_d;
    logic             wr_en_d;
    logic [9:0]       wr_col_d;
    logic [7:0]       wr_data_d;
    logic [8:0]       wr_row_d;
    logic [8:0]       head_row_d;
    logic             overflow_d;
    logic [BIN_W-1:0] shifted;
    logic [7:0]       pix;
    logic [7:0]       col_pix;
    logic             take;
    logic             hs;

    // vsync is active-low: a frame starts on its falling edge
    assign tick        = vsync_q & ~vsync;
    assign shifted     = s_bin_data >> SHIFT;
    assign pix         = (shifted > BIN_W'(255)) ? 8'hFF : shifted[7:0];
    assign s_bin_ready = (state == CAPTURE) || (state == DRAIN);
    assign hs          = s_bin_valid & s_bin_ready;

`ifdef WATERFALL_MAX_POOL_EN
    // Pair state: phase=1 means the first bin of a column pair is held
    logic       phase, phase_d;
    logic [7:0] held, held_d;

    // Column is written on the second bin of a pair, or early on a lone last bin
    assign take    = phase | s_bin_last;
    assign col_pix = phase ? ((held > pix) ? held : pix) : pix;
`else
    assign take    = 1'b1;
    assign col_pix = pix;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state;
        frame_cnt_d = frame_cnt;
        col_d       = col;
        wr_en_d     = 1'b0;
        wr_col_d    = wr_col;
        wr_data_d   = wr_data;
        wr_row_d    = wr_row;
        head_row_d  = head_row;
        overflow_d  = overflow;
`ifdef WATERFALL_MAX_POOL_EN
        phase_d     = phase;
        held_d      = held;
`endif
        case (state)
            IDLE: begin
                // Ticks are only counted here, so a capture never restarts mid-row
                if (tick) begin
                    if (frame_cnt == FCNT_LAST) begin
                        frame_cnt_d = 4'd0;
                        col_d       = 10'd0;
                        state_d     = CAPTURE;
`ifdef WATERFALL_MAX_POOL_EN
                        phase_d     = 1'b0;
`endif
                    end else begin
                        frame_cnt_d = frame_cnt + 4'd1;
                    end
                end
            end
            CAPTURE: begin
                if (hs) begin
`ifdef WATERFALL_MAX_POOL_EN
                    phase_d = ~take;
                    if (!take) begin
                        held_d = pix;
                    end
`endif
                    if (take) begin
                        wr_en_d   = 1'b1;
                        wr_col_d  = col;
                        wr_data_d = col_pix;
                        if (s_bin_last) begin
                            state_d = (col == COL_LAST) ? COMMIT : PAD;
                        end else if (col == COL_LAST) begin
                            state_d = DRAIN;
                        end else begin
                            col_d = col + 10'd1;
                        end
                    end
                end
            end
            PAD: begin
                // Blank the remainder of a short row so stale pixels never show
                wr_en_d   = 1'b1;
                wr_col_d  = col + 10'd1;
                wr_data_d = 8'd0;
                col_d     = col + 10'd1;
                if (col + 10'd1 == COL_LAST) begin
                    state_d = COMMIT;
                end
            end
            DRAIN: begin
                if (hs) begin
                    overflow_d = 1'b1;
                    if (s_bin_last) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                // wr_row only moves here, keeping it constant across a row
                head_row_d = wr_row;
                wr_row_d   = (wr_row == ROW_LAST) ? 9'd0 : wr_row + 9'd1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q   <= 1'b0;
            frame_cnt <= 4'd0;
            col       <= 10'd0;
            wr_en     <= 1'b0;
            wr_col    <= 10'd0;
            wr_data   <= 8'd0;
            wr_row    <= 9'd0;
            head_row  <= 9'd0;
            overflow  <= 1'b0;
`ifdef WATERFALL_MAX_POOL_EN
            phase     <= 1'b0;
            held      <= 8'd0;
`endif
        end else begin
            vsync_q   <= vsync;
            frame_cnt <= frame_cnt_d;
            col       <= col_d;
            wr_en     <= wr_en_d;
            wr_col    <= wr_col_d;
            wr_data   <= wr_data_d;
            wr_row    <= wr_row_d;
            head_row  <= head_row_d;
            overflow  <= overflow_d;
`ifdef WATERFALL_MAX_POOL_EN
            phase     <= phase_d;
            held      <= held_d;
`endif
        end
    end

endmodule

// File: tb/tb_waterfall_writer.sv
`timescale 1ns/1ps
// Bench for waterfall_writer: directed and randomized frames against a row-level reference model.
// Row width is reduced so that a full 181-frame wrap stays short; row count is the real 180.
// A second instance with FRAMES_PER_ROW=3 checks the capture cadence.
module tb_waterfall_writer;

    localparam int TB_COLS = 64;
    localparam int TB_ROWS = 180;
    localparam int TB_SHIFT = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] s_bin_data;
    logic        s_bin_valid;
    logic        s_bin_last;
    logic        s_bin_ready;
    logic        vsync;
    logic        wr_en;
    logic [8:0]  wr_row;
    logic [9:0]  wr_col;
    logic [7:0]  wr_data;
    logic [8:0]  head_row;
    logic        overflow;

    logic [15:0] d3_data;
    logic        d3_valid;
    logic        d3_last;
    logic        d3_ready;
    logic        vsync3;
    logic        d3_wr_en;
    logic [8:0]  d3_wr_row;
    logic [9:0]  d3_wr_col;
    logic [7:0]  d3_wr_data;
    logic [8:0]  d3_head_row;
    logic        d3_overflow;

    int vectors     = 0;
    int miscompares = 0;
    bit stuck       = 0;

    logic [26:0] cap_q[$];
    logic [15:0] fq[$];
    int m_row, m_head, m_ovf;
    int r3_cnt  = 0;
    int w3_cnt  = 0;
    logic [17:0] w3_last;

    waterfall_writer #(
        .NUM_ROWS(TB_ROWS), .NUM_COLS(TB_COLS), .BIN_W(16), .SHIFT(TB_SHIFT), .FRAMES_PER_ROW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_bin_data(s_bin_data), .s_bin_valid(s_bin_valid), .s_bin_last(s_bin_last),
        .s_bin_ready(s_bin_ready), .vsync(vsync),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .head_row(head_row), .overflow(overflow)
    );

    waterfall_writer #(
        .NUM_ROWS(TB_ROWS), .NUM_COLS(TB_COLS), .BIN_W(16), .SHIFT(TB_SHIFT), .FRAMES_PER_ROW(3)
    ) dut3 (
        .clk(clk), .rst_n(rst_n),
        .s_bin_data(d3_data), .s_bin_valid(d3_valid), .s_bin_last(d3_last),
        .s_bin_ready(d3_ready), .vsync(vsync3),
        .wr_en(d3_wr_en), .wr_row(d3_wr_row), .wr_col(d3_wr_col), .wr_data(d3_wr_data),
        .head_row(d3_head_row), .overflow(d3_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_en) cap_q.push_back({wr_row, wr_col, wr_data});
        if (d3_ready) r3_cnt++;
        if (d3_wr_en) begin
            w3_cnt++;
            w3_last = {d3_wr_col, d3_wr_data};
        end
    end

    function automatic int sat8(input int b);
        int v;
        v = b >> TB_SHIFT;
        return (v > 255) ? 255 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_vsync();
        vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1 vsync = 1'b1;
    endtask

    task automatic push_bin(input logic [15:0] d, input logic l);
        int budget;
        budget = 200;
        if (stuck) return;
        s_bin_data  = d;
        s_bin_last  = l;
        s_bin_valid = 1'b1;
        @(negedge clk);
        while (!s_bin_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("bin_accept", 32'(s_bin_ready), 32'd1);
        if (!s_bin_ready) begin
            stuck = 1;
            s_bin_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 s_bin_valid = 1'b0;
    endtask

    // Sends fq as one frame and checks the row it produces against the model
    task automatic send_frame(input bit stalls);
        int len, n;
        int exp;
        len = fq.size();
        cap_q.delete();
        pulse_vsync();
        for (int i = 0; i < len; i++) begin
            if (stalls && $urandom_range(0, 3) == 0) begin
                s_bin_valid = 1'b0;
                s_bin_data  = 16'($urandom);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            push_bin(fq[i], (i == len - 1));
            if (i < TB_COLS) begin
                chk("wr_en_latency", 32'(wr_en), 32'd1);
                chk("wr_col_data", 32'({wr_col, wr_data}), 32'({10'(i), 8'(sat8(fq[i]))}));
            end else begin
                chk("drain_no_write", 32'(wr_en), 32'd0);
            end
            if (i == 0) begin
                chk("head_hold", 32'(head_row), 32'(m_head));
                chk("row_hold", 32'(wr_row), 32'(m_row));
            end
            if (i == TB_COLS - 1 && len > TB_COLS) chk("ovf_before", 32'(overflow), 32'(m_ovf));
            if (i == TB_COLS) chk("ovf_set", 32'(overflow), 32'd1);
        end
        repeat (TB_COLS + 4) @(posedge clk);
        #1;
        chk("row_write_count", 32'(cap_q.size()), 32'(TB_COLS));
        n = (cap_q.size() < TB_COLS) ? cap_q.size() : TB_COLS;
        for (int c = 0; c < n; c++) begin
            exp = (c < len) ? sat8(fq[c]) : 0;
            chk("row_pixel", 32'(cap_q[c]), 32'({9'(m_row), 10'(c), 8'(exp)}));
        end
        m_head = m_row;
        m_row  = (m_row + 1) % TB_ROWS;
        if (len > TB_COLS) m_ovf = 1;
        chk("head_row", 32'(head_row), 32'(m_head));
        chk("wr_row_next", 32'(wr_row), 32'(m_row));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("idle_ready", 32'(s_bin_ready), 32'd0);
    endtask

    task automatic rand_frame(input int len);
        fq.delete();
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 1) == 1) fq.push_back(16'($urandom));
            else fq.push_back(16'($urandom_range(0, 4095)));
        end
    endtask

    initial begin
        int p3, w3p;
        rst_n = 1'b0;
        s_bin_data = 16'd0; s_bin_valid = 1'b0; s_bin_last = 1'b0;
        vsync = 1'b1; vsync3 = 1'b1;
        d3_data = 16'h0100; d3_valid = 1'b1; d3_last = 1'b1;
        m_row = 0; m_head = 0; m_ovf = 0;

        // Reset state
        #12;
        chk("rst_ready", 32'(s_bin_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_row", 32'(wr_row), 32'd0);
        chk("rst_wr_col", 32'(wr_col), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_head_row", 32'(head_row), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("post_rst_ready", 32'(s_bin_ready), 32'd0);
        chk("post_rst_wr_en", 32'(wr_en), 32'd0);

        // Full row of 0x0120 -> pixel 0x12 everywhere
        fq.delete();
        for (int i = 0; i < TB_COLS; i++) fq.push_back(16'h0120);
        send_frame(0);
        chk("full_pixel_const", 32'(cap_q[TB_COLS-1][7:0]), 32'h12);
        chk("full_head", 32'(head_row), 32'd0);
        chk("full_wr_row", 32'(wr_row), 32'd1);

        // Saturation and short-frame padding
        fq.delete();
        fq.push_back(16'hFFFF); fq.push_back(16'h0FF0); fq.push_back(16'h0010);
        send_frame(0);
        chk("sat_col0", 32'(cap_q[0][7:0]), 32'd255);
        chk("sat_col1", 32'(cap_q[1][7:0]), 32'd255);
        chk("sat_col2", 32'(cap_q[2][7:0]), 32'd1);

        // Overflow: NUM_COLS + 60 bins, row still commits
        rand_frame(TB_COLS + 60);
        send_frame(1);

        // Reset in the middle of a capture
        rand_frame(20);
        pulse_vsync();
        for (int i = 0; i < 20; i++) push_bin(fq[i], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(s_bin_ready), 32'd0);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_wr_row", 32'(wr_row), 32'd0);
        chk("mid_rst_wr_col", 32'(wr_col), 32'd0);
        chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
        chk("mid_rst_head", 32'(head_row), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        m_row = 0; m_head = 0; m_ovf = 0;

        // 181 frames from reset: rows 0..179 then wrap to 0
        for (int nf = 1; nf <= 181; nf++) begin
            rand_frame((nf == 1) ? 10 : $urandom_range(1, TB_COLS + 12));
            send_frame(1);
            if (nf == 180) begin
                chk("wrap_head_179", 32'(head_row), 32'd179);
                chk("wrap_row_0", 32'(wr_row), 32'd0);
            end
            if (nf == 181) begin
                chk("wrap_head_0", 32'(head_row), 32'd0);
                chk("wrap_row_1", 32'(wr_row), 32'd1);
            end
        end

        // FRAMES_PER_ROW=3: only every third tick captures
        for (int k = 1; k <= 9; k++) begin
            p3  = r3_cnt;
            w3p = w3_cnt;
            vsync3 = 1'b0;
            repeat (2) @(posedge clk);
            #1 vsync3 = 1'b1;
            repeat (TB_COLS + 16) @(posedge clk);
            #1;
            chk("fpr3_ready_cycles", 32'(r3_cnt - p3), (k % 3 == 0) ? 32'd1 : 32'd0);
            chk("fpr3_writes", 32'(w3_cnt - w3p), (k % 3 == 0) ? 32'(TB_COLS) : 32'd0);
            chk("fpr3_wr_row", 32'(d3_wr_row), 32'(k / 3));
        end
        chk("fpr3_last_write", 32'(w3_last), 32'({10'(TB_COLS - 1), 8'd0}));
        chk("fpr3_head", 32'(d3_head_row), 32'd2);
        chk("fpr3_overflow", 32'(d3_overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/waterfall_writer.md
Name: waterfall_writer

Overview:
- Write-side companion of the waterfall buffer. Accepts one spectrum frame of magnitude bins per row-update over a valid/ready stream and compresses each bin to an 8-bit pixel.
- Writes each row into the circular waterfall RAM (NUM_ROWS x NUM_COLS), frame-locked to display vsync so a row update never tears mid-frame.
- Publishes head_row (newest complete row) so the display-side read path can offset its rd_row into the circular buffer.

Parameters:
- NUM_ROWS, 180, rows in the circular buffer (waterfall region height).
- NUM_COLS, 640, pixels per row.
- BIN_W, 16, input magnitude width.
- SHIFT, 4, right shift applied to the bin before 8-bit saturation.
- FRAMES_PER_ROW, 1, vsync frames per captured row (1..15).

Ports:
- clk  in  1  pixel/system clock
- rst_n  in  1  asynchronous active-low reset
- s_bin_data  in  BIN_W  magnitude bin
- s_bin_valid  in  1  bin valid
- s_bin_last  in  1  last bin of spectrum frame
- s_bin_ready  out  1  block accepts bin
- vsync  in  1  display vsync, active-low
- wr_en  out  1  RAM write strobe
- wr_row  out  9  RAM row address
- wr_col  out  10  RAM column address
- wr_data  out  8  pixel value
- head_row  out  9  newest fully written row
- overflow  out  1  sticky: a frame exceeded NUM_COLS bins

Behaviour:
- Reset (async on rst_n low; sync release): state=IDLE, s_bin_ready=0, wr_en=0, wr_row=0, wr_col=0, wr_data=0, head_row=0, overflow=0, frame counter=0. A partial row in progress is abandoned; no commit.
- Frame tick: one-cycle pulse on the vsync falling edge, detected from a registered copy of vsync. The frame counter counts ticks in IDLE only. A capture starts when the counter reaches FRAMES_PER_ROW-1; the counter then clears.
- IDLE: s_bin_ready=0. On a qualifying tick, go to CAPTURE with col=0.
- CAPTURE: s_bin_ready=1. On each handshake (valid&&ready):
  - register wr_en=1, wr_col=col, wr_data=sat8(s_bin_data>>SHIFT); 1-cycle latency from handshake to write.
  - sat8 outputs 255 if the shifted value is >255, else its low 8 bits.
  - Branching on that handshake:
    - last and col==NUM_COLS-1: go to COMMIT.
    - last and col<NUM_COLS-1: go to PAD.
    - col==NUM_COLS-1 and not last: go to DRAIN.
    - otherwise col++.
- PAD: s_bin_ready=0. Writes wr_data=0 for col+1..NUM_COLS-1, one per cycle, then go to COMMIT.
- DRAIN: s_bin_ready=1, wr_en=0. Bins are discarded and overflow set on the first discarded bin; on last, go to COMMIT.
- COMMIT (1 cycle):
  - head_row<=wr_row.
  - wr_row<=(wr_row==NUM_ROWS-1)?0:wr_row+1.
  - Return to IDLE.
- wr_en is 0 in all cycles except registered CAPTURE/PAD writes. wr_row is constant during a row.
- Ticks arriving outside IDLE are ignored and not counted.
- Back-to-back: a tick in the same cycle as COMMIT is ignored; the next capture waits for the following qualifying tick.
- Input stalls (valid low) in CAPTURE/DRAIN hold state indefinitely; no timeout.
- Display-side physical row = (head_row + 1 + rd_row) mod NUM_ROWS, giving oldest-at-top order.

Optional Feature:
- Macro WATERFALL_MAX_POOL_EN.
- Defined: each column is the max of two consecutive accepted bins. The write occurs on the second bin of each pair (odd accepted index). A last on an even index writes that single bin, then pads. Overflow/DRAIN applies after NUM_COLS columns (2*NUM_COLS bins).
- Undefined: one bin per column, as above.

Test Plan:
- Reset mid-capture: assert rst_n=0 after 100 bins -> all outputs 0 immediately; after release, wait for tick; the first row is written at wr_row=0 and head_row stays 0 until COMMIT.
- Full row: 640 bins of value 0x0120 ending with last -> 640 writes, wr_data=0x12, wr_col 0..639; head_row=0, wr_row=1; overflow=0.
- Saturation/short frame: bins 0xFFFF,0x0FF0,0x0010 with last on the third -> wr_data 255,255,1 at cols 0..2, then 637 zero writes at cols 3..639.
- Overflow: 700 bins, last on the 700th -> 640 writes; overflow=1 from bin 641; the row still commits.
- Wrap: 181 consecutive frames -> wr_row sequence 0..179,0; head_row=179 after frame 180, 0 after frame 181.
- FRAMES_PER_ROW=3: ticks every frame with bins always valid -> a capture starts only on ticks 3, 6, 9...; s_bin_ready=0 between captures.
